// File: rtl/mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// mealy_pattern_detector
//   Runtime-programmable Mealy serial sequence detector. Consumes one bit per
//   cycle when bit_valid is high and tracks how much of the loaded pattern has
//   been seen, using KMP failure-function behaviour.
//
//   Parameters
//     PAT_W  pattern length in bits (2..8)
//     CNT_W  width of the saturating match counter
//     SW     state index width, clog2(PAT_W); derived, do not override
//
//   Ports
//     clk          rising-edge clock
//     rst_n        synchronous, active-low reset
//     bit_valid    bit_in is consumed this cycle
//     bit_in       serial data bit
//     cfg_load     one-cycle pulse: capture cfg_pattern / cfg_overlap
//     cfg_pattern  pattern, MSB is the first bit expected
//     cfg_overlap  1 = overlapping detection, 0 = restart after a match
//     clr_count    synchronous clear of match_count (wins over increment)
//     match        combinational Mealy match
//     match_q      match delayed by one cycle
//     state        matched-prefix length, 0..PAT_W-1
//     match_count  saturating match count
// -----------------------------------------------------------------------------
module mealy_pattern_detector #(
  parameter  int PAT_W = 4,
  parameter  int CNT_W = 8,
  localparam int SW    = $clog2(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clr_count,
  output logic             match,
  output logic             match_q,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_count
);

  logic [SW-1:0]    state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             ovl_q, ovl_d;
  logic [PAT_W-2:0] hist_q, hist_d;   // last PAT_W-1 accepted bits, [0] newest
  logic             match_q_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [PAT_W-1:0] win;              // history plus the incoming bit
  logic [SW-1:0]    nxt;              // KMP successor of the current state
  logic             ok;
  int               st_int;

  always_comb begin
    win       = {hist_q, bit_in};
    st_int    = int'(state_q);
    nxt       = '0;
    ok        = 1'b0;
    state_d   = state_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    hist_d    = hist_q;
    match     = bit_valid & ~cfg_load & (state_q == SW'(PAT_W-1)) & (bit_in == pat_q[0]);
    match_q_d = match;

    // Longest k < PAT_W such that the newest k bits equal the first k pattern
    // bits. Only bits inside the current prefix (k <= state+1) are trusted;
    // older history bits may predate a restart. On a full match this yields
    // the longest proper border of the pattern, i.e. the overlap successor.
    for (int k = 1; k < PAT_W; k++) begin
      ok = (k <= st_int + 1);
      for (int j = 0; j < k; j++) begin
        if (win[j] != pat_q[PAT_W-k+j]) ok = 1'b0;
      end
      if (ok) nxt = SW'(k);
    end

    if (cfg_load) begin
      // A bit arriving with cfg_load is dropped; detection restarts cleanly.
      pat_d   = cfg_pattern;
      ovl_d   = cfg_overlap;
      state_d = '0;
    end else if (bit_valid) begin
      hist_d  = win[PAT_W-2:0];
      state_d = (match && !ovl_q) ? '0 : nxt;
    end

    // Encodings >= PAT_W are unreachable; recover to 0 if ever seen.
    if (st_int >= PAT_W) state_d = '0;

    count_d = count_q;
    if (clr_count)                count_d = '0;
    else if (match && !(&count_q)) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      match_q <= match_q_d;
      count_q <= count_d;
    end
  end

  assign state       = state_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_mealy_pattern_detector.sv
// -----------------------------------------------------------------------------
// tb_mealy_pattern_detector
//   Two instances: A (PAT_W=4, CNT_W=8) and B (PAT_W=2, CNT_W=2) share the
//   stimulus; one phase at a time is checked. The driver pushes expected
//   outputs from a stream-level reference model (suffix/prefix search over the
//   bits accepted since the last restart); the monitor pops and compares on
//   the falling edge.
// -----------------------------------------------------------------------------
module tb_mealy_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n, bit_valid, bit_in, cfg_load, cfg_overlap, clr_count;
  logic [3:0] cfg_pattern;

  logic       a_match, a_match_q;
  logic [1:0] a_state;
  logic [7:0] a_count;
  logic       b_match, b_match_q;
  logic [0:0] b_state;
  logic [1:0] b_count;

  always #5 clk = ~clk;

  mealy_pattern_detector #(.PAT_W(4), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(a_match), .match_q(a_match_q),
    .state(a_state), .match_count(a_count));

  mealy_pattern_detector #(.PAT_W(2), .CNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern[1:0]), .cfg_overlap(cfg_overlap),
    .clr_count(clr_count), .match(b_match), .match_q(b_match_q),
    .state(b_state), .match_count(b_count));

  typedef struct {
    bit sel;
    bit m;
    int st;
    bit mq;
    int cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model
  bit hq[$];      // accepted bits since last restart, oldest first
  int m_pat, m_patw, m_cntmax;
  bit m_ovl, m_mq, sel;
  int m_cnt;
  bit cur_ovl;
  int cur_pat;

  // Largest k <= maxk whose last k stream bits equal the first k pattern bits.
  function automatic int suff_pref(bit s[$], int maxk);
    int best = 0;
    for (int k = 1; k <= maxk && k <= s.size(); k++) begin
      bit ok = 1'b1;
      for (int j = 0; j < k; j++)
        if (s[s.size()-k+j] != m_pat[m_patw-1-j]) ok = 1'b0;
      if (ok) best = k;
    end
    return best;
  endfunction

  task automatic model_reset();
    hq.delete();
    m_pat = 0; m_ovl = 1'b1; m_mq = 1'b0; m_cnt = 0;
  endtask

  task automatic drive(bit v, bit b, bit ld, int pat, bit ovl, bit clr, bit rn);
    exp_t e;
    bit   tmp[$];
    bit   m;
    @(posedge clk); #1;
    bit_valid = v; bit_in = b; cfg_load = ld; cfg_pattern = pat[3:0];
    cfg_overlap = ovl; clr_count = clr; rst_n = rn;
    tmp = hq;
    tmp.push_back(b);
    m = v && !ld && (suff_pref(tmp, m_patw) == m_patw);
    e.sel = sel; e.m = m; e.st = suff_pref(hq, m_patw-1); e.mq = m_mq; e.cnt = m_cnt;
    sb.push_back(e);
    if (!rn) model_reset();
    else begin
      m_mq = m;
      if (clr) m_cnt = 0;
      else if (m && m_cnt < m_cntmax) m_cnt++;
      if (ld) begin
        m_pat = pat; m_ovl = ovl; hq.delete();
      end else if (v) begin
        hq.push_back(b);
        while (hq.size() > m_patw) void'(hq.pop_front());
        if (m && !m_ovl) hq.delete();
      end
    end
  endtask

  task automatic step(bit b);
    drive(1'b1, b, 1'b0, cur_pat, cur_ovl, 1'b0, 1'b1);
  endtask
  task automatic idle();
    drive(1'b0, 1'($urandom), 1'b0, cur_pat, cur_ovl, 1'b0, 1'b1);
  endtask
  task automatic load(int pat, bit ovl);
    cur_pat = pat; cur_ovl = ovl;
    drive(1'b0, 1'b0, 1'b1, pat, ovl, 1'b0, 1'b1);
  endtask
  task automatic do_reset();
    cur_pat = 0; cur_ovl = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic clr();
    drive(1'b0, 1'b0, 1'b0, cur_pat, cur_ovl, 1'b1, 1'b1);
  endtask
  task automatic stream(int bits, int n);
    for (int i = n-1; i >= 0; i--) step(bits[i]);
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          chk("match",   32'(a_match),   32'(e.m));
          chk("state",   32'(a_state),   32'(e.st));
          chk("match_q", 32'(a_match_q), 32'(e.mq));
          chk("count",   32'(a_count),   32'(e.cnt));
        end else begin
          chk("b_match",   32'(b_match),   32'(e.m));
          chk("b_state",   32'(b_state),   32'(e.st));
          chk("b_match_q", 32'(b_match_q), 32'(e.mq));
          chk("b_count",   32'(b_count),   32'(e.cnt));
        end
      end
    end
  end

  task automatic random_run(int n);
    for (int i = 0; i < n; i++) begin
      int  r   = int'($urandom_range(0, 99));
      bit  ld  = (r < 3);
      bit  rs  = (r == 99);
      bit  cl  = ($urandom_range(0, 49) == 0);
      if (ld) begin
        cur_pat = int'($urandom_range(0, 15));
        cur_ovl = 1'($urandom);
      end
      if (rs) do_reset();
      else drive(1'($urandom_range(0, 3) != 0), 1'($urandom), ld, cur_pat, cur_ovl, cl, 1'b1);
    end
  endtask

  initial begin
    sel = 1'b0; m_patw = 4; m_cntmax = 255;
    cur_pat = 0; cur_ovl = 1'b1;
    rst_n = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_overlap = 1'b1; clr_count = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    do_reset();                    // reset values observed on the next entry

    // power-on pattern 0000 overlapping: zeros match after four
    stream(32'b000000, 6);
    do_reset();

    // 1011 overlapping
    load(4'b1011, 1'b1);
    stream(32'b1011011, 7);
    clr();
    // 1011 non-overlapping
    load(4'b1011, 1'b0);
    stream(32'b1011011, 7);
    // 0000 both modes
    load(4'b0000, 1'b1);
    stream(32'b000000, 6);
    load(4'b0000, 1'b0);
    stream(32'b000000, 6);
    // gaps between bits
    load(4'b1011, 1'b1);
    for (int i = 6; i >= 0; i--) begin
      bit [6:0] s = 7'b1011011;
      step(s[i]);
      repeat (3) idle();
    end
    // cfg_load concurrent with a would-be bit
    load(4'b1011, 1'b1);
    stream(32'b101, 3);
    cur_pat = 4'b0110; cur_ovl = 1'b1;
    drive(1'b1, 1'b1, 1'b1, cur_pat, cur_ovl, 1'b0, 1'b1);
    stream(32'b0110, 4);
    // reset mid-stream
    stream(32'b011, 3);
    do_reset();
    stream(32'b0000, 4);

    random_run(1500);

    // instance B: PAT_W=2, CNT_W=2
    repeat (2) @(posedge clk);
    sel = 1'b1; m_patw = 2; m_cntmax = 3;
    do_reset();
    load(2'b11, 1'b1);
    stream(32'b1111111, 7);        // count saturates at 3
    drive(1'b1, 1'b1, 1'b0, cur_pat, cur_ovl, 1'b1, 1'b1);  // clr beats match
    stream(32'b11, 2);
    do_reset();
    stream(32'b00, 2);
    random_run(400);

    repeat (3) @(posedge clk);
    n_chk++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left expected 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mealy_pattern_detector.md
Name: mealy_pattern_detector

Overview:
- Parametrised, runtime-programmable Mealy serial sequence detector; the next generation of the team's fixed 5-state Mealy FSMs.
- Accepts a qualified serial bit stream and compares it against a PAT_W-bit pattern loaded at runtime.
- Raises a same-cycle Mealy match, a registered match copy and a saturating match counter.
- Supports overlapping and non-overlapping detection. No clock gating of any output.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..8.
- CNT_W, 8, width of saturating match counter.
- SW, derived = clog2(PAT_W), width of state index; not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- bit_valid  input  1  bit_in is consumed this cycle.
- bit_in  input  1  serial data bit.
- cfg_load  input  1  one-cycle pulse; captures cfg_pattern and cfg_overlap.
- cfg_pattern  input  PAT_W  pattern; bit PAT_W-1 is the first bit expected.
- cfg_overlap  input  1  1 = overlapping detection, 0 = restart after match.
- clr_count  input  1  synchronous clear of match_count.
- match  output  1  Mealy match, combinational from state, bit_in, bit_valid and pattern.
- match_q  output  1  match registered, one cycle later.
- state  output  SW  current matched-prefix length, 0..PAT_W-1.
- match_count  output  CNT_W  saturating count of matches.

Behaviour:
- Reset, sampled at clk edge while rst_n=0:
  - state=0, match_q=0, match_count=0.
  - pattern register = all zeros, overlap register = 1.
  - match therefore reads 0 unless bit_valid=1 and bit_in=0.
- State meaning: state=k means the last k accepted bits equal pattern[PAT_W-1 -: k].
- Mealy output: match = bit_valid & ~cfg_load & (state==PAT_W-1) & (bit_in==pattern[0]).
  - match is not gated by clk.
- Next state, only when bit_valid=1 and cfg_load=0:
  - Let s' be the sequence of the state accepted bits followed by bit_in, of length state+1.
  - Not a match: next state = the largest k <= state+1, k < PAT_W, such that the last k bits of s' equal the first k pattern bits. This is KMP failure-function behaviour; 0 if no such k.
  - Match, overlap=1: next state = the longest proper border of the full pattern (largest k < PAT_W with prefix_k == suffix_k).
  - Match, overlap=0: next state = 0.
  - The implementation may compute this from the pattern register alone or from a PAT_W-1 bit history register. Results must be identical.
- bit_valid=0: state, match_count and the internal registers hold; match=0.
- match_q: registered copy of match each cycle, including cycles where match=0.
- match_count:
  - Increments by 1 on each cycle where match=1.
  - Saturates at all-ones and never wraps.
  - clr_count=1 forces 0 next cycle and has priority over an increment in the same cycle.
- cfg_load=1:
  - Pattern and overlap registers load from the inputs next edge; state forced to 0.
  - A concurrent bit is discarded: match forced 0, no count.
  - match_count is not affected by cfg_load.
- Reset mid-stream: all state is lost; detection restarts from state 0 with an all-zero, overlapping pattern.
- No illegal states reachable. Any state value >= PAT_W (unreachable) maps to 0 next cycle.

Test Plan:
- Pattern 1011, overlap=1, stream 1,0,1,1,0,1,1, bit_valid continuous -> match high on bits 4 and 7; match_q one cycle after each; match_count=2; state sequence 1,2,3,1,2,3,1.
- Same pattern and stream with overlap=0 -> match only on bit 4; state returns to 0 after bit 4; match_count=1.
- Pattern 0000, overlap=1, six zeros -> match on bits 4, 5, 6; match_count=3. The same stream with overlap=0 -> match on bit 4 only.
- Pattern 1011 stream with bit_valid low for 3 cycles between every bit -> identical match positions to the first scenario. state holds during gaps; match=0 during gaps even when bit_in toggles.
- After 1,0,1 (state=3), pulse cfg_load with pattern 0110 while bit_valid=1 and bit_in=1 -> no match, match_count unchanged, state=0. Then 0,1,1,0 -> one match.
- CNT_W=2, pattern 11 overlap=1, seven ones -> match on bits 2..7, match_count sticks at 3. clr_count together with a match -> match_count=0. Assert rst_n=0 mid-stream -> all outputs at their reset values next edge.
